// File: rtl/instr_issue_ctrl.sv
// Instruction queue and issue controller: buffers host instructions, filters
// illegal opcodes and issues one at a time to the matrix coprocessor.
module instr_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             host_instr,
  input  logic                    host_valid,
  output logic                    host_ready,
  output logic [31:0]             cp_instruction,
  output logic                    cp_activate,
  input  logic                    cp_done,
  input  logic                    clear_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err_overflow,
  output logic                    err_illegal,
  output logic                    err_timeout,
  output logic [15:0]             issued_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [WW-1:0]   wdog;
  logic            done_prev;
  logic [31:0]     head;
  logic            full, push, pop, head_legal, done_rise;
  logic            illegal_set, timeout_set, overflow_set;

  assign full       = (fifo_count == FULL_CNT);
  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign host_ready = rst_n & ~full;
  assign push       = host_valid & host_ready;
  assign pop        = (state == IDLE) && (fifo_count != '0);
  assign head       = mem[rd_ptr];
  assign head_legal = (head[3:0] != 4'd0) && (head[3:0] <= 4'd12);
  assign done_rise  = cp_done & ~done_prev;
  assign busy       = (fifo_count != '0) || (state != IDLE);

  assign illegal_set  = pop & ~head_legal;
  assign timeout_set  = (state == WAIT) && !done_rise && (wdog == WD_LAST);
  assign overflow_set = host_valid & full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cp_instruction <= '0;
      cp_activate    <= 1'b0;
      wdog           <= '0;
      issued_cnt     <= '0;
      done_prev      <= 1'b0;
    end else begin
      done_prev <= cp_done;
      unique case (state)
        IDLE: begin
          if (pop && head_legal) begin
            cp_instruction <= head;
            cp_activate    <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cp_activate <= 1'b0;
          wdog        <= '0;
          issued_cnt  <= issued_cnt + 1'b1;
          state       <= WAIT;
        end
        WAIT: begin
          // wdog holds completed WAIT cycles, so the current cycle is wdog+1.
          if (done_rise || wdog == WD_LAST) state <= GAP;
          else                              wdog  <= wdog + 1'b1;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_overflow <= (err_overflow & ~clear_err) | overflow_set;
      err_illegal  <= (err_illegal  & ~clear_err) | illegal_set;
      err_timeout  <= (err_timeout  & ~clear_err) | timeout_set;
    end
  end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench for instr_issue_ctrl; issued words are checked against
// a queue of expected instructions filled as the host pushes.
module tb_instr_issue_ctrl;

  logic        clk, rst_n;
  logic [31:0] host_instr;
  logic        host_valid, host_ready;
  logic [31:0] cp_instruction;
  logic        cp_activate, cp_done, clear_err, busy;
  logic [2:0]  fifo_count;
  logic        err_overflow, err_illegal, err_timeout;
  logic [15:0] issued_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_issued = '0;

  instr_issue_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_instr(host_instr), .host_valid(host_valid), .host_ready(host_ready),
    .cp_instruction(cp_instruction), .cp_activate(cp_activate),
    .cp_done(cp_done), .clear_err(clear_err), .busy(busy),
    .fifo_count(fifo_count), .err_overflow(err_overflow),
    .err_illegal(err_illegal), .err_timeout(err_timeout),
    .issued_cnt(issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit legal(input logic [31:0] w);
    logic [3:0] op;
    op = w[3:0];
    return (op >= 4'd1) && (op <= 4'd12);
  endfunction

  task automatic push(input logic [31:0] w);
    host_instr = w;
    host_valid = 1'b1;
    if (host_ready && legal(w)) exp_q.push_back(w);
    tick();
    host_valid = 1'b0;
  endtask

  task automatic pulse_done();
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
  endtask

  // Waits for an issue strobe, checks it against the scoreboard and checks
  // that the strobe lasts exactly one cycle.
  task automatic wait_issue(input int max_cycles);
    logic [31:0] exp;
    int n = 0;
    while (!cp_activate && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (cp_activate !== 1'b1) begin
      errors++;
      $display("FAIL issue_wait: cp_activate=%b required 1 within %0d cycles", cp_activate, max_cycles);
    end else begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: cp_instruction=%h issued, required no issue", cp_instruction);
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if (cp_instruction !== exp) begin
          errors++;
          $display("FAIL issue_order: cp_instruction=%h required %h", cp_instruction, exp);
        end
      end
      exp_issued++;
      tick();
      checks++;
      if (cp_activate !== 1'b0) begin
        errors++;
        $display("FAIL strobe_width: cp_activate=%b required 0", cp_activate);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_valid = 1'b0; host_instr = '0; cp_done = 1'b0; clear_err = 1'b0;
    tick(); tick();
    checks++;
    if ({host_ready, cp_activate, busy, fifo_count, issued_cnt, cp_instruction,
         err_overflow, err_illegal, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b act=%b busy=%b cnt=%0d issued=%0d instr=%h errs=%b%b%b required all 0",
               host_ready, cp_activate, busy, fifo_count, issued_cnt, cp_instruction,
               err_overflow, err_illegal, err_timeout);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (host_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: host_ready=%b required 1", host_ready);
    end
    tick();
    push(32'h0000_0003);
    wait_issue(4);
    push(32'h0000_0004);
    push(32'h0000_0005);
    push(32'h0000_0006);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL midwait_count: fifo_count=%0d required 3", fifo_count);
    end
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_issued = '0;
    tick();
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b0 || cp_activate !== 1'b0 || issued_cnt !== exp_issued) begin
      errors++;
      $display("FAIL midwait_reset: cnt=%0d busy=%b act=%b issued=%0d required 0 0 0 %0d",
               fifo_count, busy, cp_activate, issued_cnt, exp_issued);
    end
  endtask

  task automatic test_single_issue();
    push(32'h0000_0003);
    checks++;
    if (cp_activate !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL single_push: act=%b cnt=%0d required 0 1", cp_activate, fifo_count);
    end
    tick();
    checks++;
    if (cp_activate !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_latency: act=%b cnt=%0d required 1 0", cp_activate, fifo_count);
    end
    wait_issue(0);
    repeat (4) tick();
    pulse_done();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap_busy: busy=%b required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || issued_cnt !== exp_issued) begin
      errors++;
      $display("FAIL single_done: busy=%b issued=%0d required 0 %0d", busy, issued_cnt, exp_issued);
    end
  endtask

  task automatic test_back_to_back();
    push(32'h0000_0001);
    wait_issue(4);
    push(32'hA5A5_0002);
    push(32'h1234_0004);
    push(32'hDEAD_0005);
    push(32'hBEEF_000C);
    checks++;
    if (fifo_count !== 3'd4 || host_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: cnt=%0d ready=%b required 4 0", fifo_count, host_ready);
    end
    push(32'h7777_0007);
    checks++;
    if (err_overflow !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL overflow: err_overflow=%b cnt=%0d required 1 4", err_overflow, fifo_count);
    end
    pulse_done();
    repeat (4) begin
      wait_issue(6);
      pulse_done();
    end
    tick();
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0 || issued_cnt !== exp_issued || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b left=%0d issued=%0d tmo=%b required 0 0 %0d 0",
               busy, exp_q.size(), issued_cnt, exp_issued, err_timeout);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: err_overflow=%b required 0", err_overflow);
    end
  endtask

  task automatic test_illegal();
    push(32'h0000_000F);
    push(32'h0000_0001);
    checks++;
    if (err_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag: err_illegal=%b required 1", err_illegal);
    end
    wait_issue(4);
    pulse_done();
    tick(); tick();
    checks++;
    if (issued_cnt !== exp_issued || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_count: issued=%0d busy=%b required %0d 0", issued_cnt, busy, exp_issued);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: err_illegal=%b required 0", err_illegal);
    end
    // Opcode 0 is dropped on the same edge that clear_err is high: set wins.
    clear_err = 1'b1;
    push(32'h0000_0000);
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_illegal !== 1'b1 || busy !== 1'b0 || cp_activate !== 1'b0) begin
      errors++;
      $display("FAIL illegal_set_wins: err_illegal=%b busy=%b act=%b required 1 0 0", err_illegal, busy, cp_activate);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic test_timeout();
    push(32'h0000_0007);
    push(32'h0000_0008);
    wait_issue(2);
    repeat (7) tick();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err_timeout=%b required 0 after 7 WAIT cycles", err_timeout);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: err_timeout=%b required 1 after 8 WAIT cycles", err_timeout);
    end
    tick();
    checks++;
    if (cp_activate !== 1'b0) begin
      errors++;
      $display("FAIL timeout_gap: cp_activate=%b required 0", cp_activate);
    end
    tick();
    checks++;
    if (cp_activate !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next: cp_activate=%b required 1", cp_activate);
    end
    wait_issue(0);
    pulse_done();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err_timeout=%b required 0", err_timeout);
    end
    tick();
  endtask

  task automatic test_stale_done();
    cp_done = 1'b1;
    push(32'h0000_0009);
    wait_issue(4);
    push(32'h0000_000A);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cp_activate !== 1'b0 || fifo_count !== 3'd1) begin
        errors++;
        $display("FAIL stale_done: act=%b cnt=%0d required 0 1", cp_activate, fifo_count);
      end
    end
    cp_done = 1'b0;
    tick();
    pulse_done();
    wait_issue(4);
    pulse_done();
    tick(); tick();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b0 || issued_cnt !== exp_issued || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stale_final: tmo=%b busy=%b issued=%0d left=%0d required 0 0 %0d 0",
               err_timeout, busy, issued_cnt, exp_q.size(), exp_issued);
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_stale_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_issue_ctrl.md
# instr_issue_ctrl

Instruction queue and issue controller placed between the host bus and the matrix coprocessor's `instruction` / `activate_instruction` inputs. Buffers host instructions in a small FIFO and issues them one at a time, only after the coprocessor signals completion of the previous one. Filters illegal opcodes, watchdogs hung operations, and exposes sticky error flags plus counters for the host.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, from 2 to 16.
- `TIMEOUT`, 4096: maximum cycles to wait for completion before aborting; must be at least 2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `host_instr`  in  32  instruction word; opcode is `host_instr[3:0]`.
- `host_valid`  in  1  push request; sampled every cycle.
- `host_ready`  out  1  FIFO not full.
- `cp_instruction`  out  32  instruction presented to the coprocessor; registered.
- `cp_activate`  out  1  one-cycle issue strobe; registered.
- `cp_done`  in  1  coprocessor completion level; a rising edge means the operation finished.
- `clear_err`  in  1  clears all sticky error flags.
- `busy`  out  1  FIFO non-empty or state not IDLE.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `err_overflow`  out  1  sticky; set by a push attempt while full.
- `err_illegal`  out  1  sticky; set when an opcode of 0 or 13–15 is dropped.
- `err_timeout`  out  1  sticky; set when `TIMEOUT` expires.
- `issued_cnt`  out  16  count of instructions issued; wraps from 0xFFFF to 0.

## Operation
- **Reset values.** All outputs are 0, state is IDLE, and the FIFO is empty. `host_ready` reads 1 once `rst_n` deasserts.
- **Push.** A push occurs when `host_valid & host_ready`. If `host_valid` is high while full, the word is dropped and `err_overflow` is set.
- **Simultaneous push and pop while full.** The push is refused, because `host_ready` is 0 in that cycle.
- **Legal opcodes.** 1 (READ), 2 (WRITE), 3 through 12 (SUM … DET5).
- **IDLE.**
  - If the FIFO is empty, remain in IDLE.
  - If the FIFO is non-empty, pop the head entry.
  - Illegal opcode: set `err_illegal`, remain in IDLE, issue nothing.
  - Legal opcode: load `cp_instruction`, set `cp_activate` to 1, go to ISSUE.
- **ISSUE.** Clear `cp_activate`, clear the watchdog, increment `issued_cnt`, go to WAIT.
- **WAIT.**
  - Rising edge of `cp_done` (current value 1, previous-cycle value 0): go to GAP.
  - Watchdog reaches `TIMEOUT`: set `err_timeout`, go to GAP.
- **GAP.** One idle cycle, then go to IDLE. This guarantees `cp_activate` is low for at least one cycle between issues.
- **`cp_done` tracking.** The previous-cycle register for `cp_done` updates every cycle in all states. A `cp_done` that is already high when WAIT is entered is therefore not treated as completion.
- **`cp_instruction`.** Holds its value until the next legal pop.
- **`clear_err`.** Clears all three sticky flags. If `clear_err` and a set condition occur in the same cycle, the flag ends up set.
- **Reset mid-operation.** Flushes the FIFO and returns to IDLE. The in-flight coprocessor operation is abandoned.

## Timing
- **Issue latency.** A push accepted at edge N into an empty FIFO while IDLE gives `cp_activate` high for the cycle after edge N+1.
- **Completion to next issue.** A `cp_done` rising edge sampled at edge M gives GAP for the cycle after M. The next `cp_activate` goes high after edge M+2 at the earliest.
- **`fifo_count`.**
  - Updates one cycle after a push or pop.
  - A push and a pop in the same cycle leave the count unchanged.
- **Watchdog.** Counts WAIT cycles starting from 1. Timeout fires on the cycle the count equals `TIMEOUT`.
- **Throughput.** At most one issue per 4 cycles: IDLE, ISSUE, at least 1 WAIT cycle, GAP.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-WAIT with 3 entries queued → after release: `fifo_count`=0, `busy`=0, `cp_activate`=0, `issued_cnt` unchanged from 0.
- **Single issue.**
  - Stimulus: push 0x0000_0003 (SUM) at edge N.
  - `cp_activate`=1 for exactly one cycle after N+1, with `cp_instruction`=0x0000_0003.
  - Stimulus: pulse `cp_done` 5 cycles later.
  - Response: `busy`=0 two cycles after the edge; `issued_cnt`=1.
- **Back-to-back and overflow.**
  - Stimulus: push 5 words while the first is stalled in WAIT.
  - Entries 2–5 fill the FIFO (DEPTH=4); a 6th push is dropped and sets `err_overflow`.
  - Issue order is preserved after the `cp_done` pulses.
- **Illegal opcode.**
  - Stimulus: queue 0x0000_000F then 0x0000_0001.
  - Response: `err_illegal`=1; only 0x…01 is issued; `issued_cnt`=1.
  - Stimulus: pulse `clear_err`. Response: flag returns to 0.
- **Timeout.**
  - Stimulus: TIMEOUT=8, issue, never raise `cp_done`.
  - Response: `err_timeout`=1 at the 8th WAIT cycle; the next queued instruction issues 2 cycles later.
- **Stale done.** Hold `cp_done`=1 across the issue → no completion is taken until `cp_done` falls and rises again.
